sram_controller: RTL
====================

// Module: sram_controller
// PURPOSE
//  MEM-stage data-memory engine. Serves one 32-bit load/store per request against an external
//  16-bit asynchronous SRAM, as two half-word accesses with programmable wait states.
//  Produces the memory_data word and the ready/freeze signal consumed by the MEM/WB pipeline
//  register and the hazard path, so the pipeline stalls until the access completes.
// PARAMETERS
//  ADDR_BASE    1024  byte address mapped to SRAM word 0
//  WAIT_STATES  5     cycles SRAM_ADDR/SRAM_DQ held per half-word access (>=1)
// PORTS
//  clk           in   1                 system clock, rising edge
//  rst           in   1                 synchronous, active-high reset
//  mem_read_en   in   1                 load request, held stable while freeze=1
//  mem_write_en  in   1                 store request, held stable while freeze=1
//  address       in   `LEN_REGISTER     byte address (ALU result)
//  write_data    in   `LEN_REGISTER     store data
//  read_data     out  `LEN_REGISTER     load result, valid when ready=1 in DONE
//  ready         out  1                 access complete or no request
//  freeze        out  1                 (mem_read_en|mem_write_en) & ~ready
//  SRAM_ADDR     out  18                SRAM half-word address
//  SRAM_DQ       inout 16               SRAM data bus
//  SRAM_WE_N     out  1                 active-low write strobe
//  SRAM_UB_N/LB_N/CE_N/OE_N out 1 each  tied 0
// BEHAVIOUR
//  Reset is synchronous, active-high; the clock/reset requirement is stated under PORTS.
//  - Reset: state=IDLE, counter=0, read_data=0, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0.
//    Reset mid-access aborts at once; no partial write is completed beyond the current cycle.
//  - word = (address-ADDR_BASE)>>2, 17 bits. SRAM_ADDR = {word[16:0], half}, where half=0 is
//    bits[15:0] and half=1 is bits[31:16]. Upper bits are truncated (wrap).
//  - FSM: IDLE -> LO -> HI -> DONE -> IDLE.
//    IDLE: leave when mem_read_en|mem_write_en; clear the counter.
//    LO/HI: drive the half address. On a write, drive SRAM_DQ with the half data and hold
//      SRAM_WE_N=0 for cycles 0..WAIT_STATES-2 of the phase, then 1 on the last cycle
//      (data hold). On a read, SRAM_DQ=Z and the half is latched on the last cycle.
//      Stay WAIT_STATES cycles per phase; counter wraps to 0 on phase change.
//    DONE: one cycle, ready=1, read_data stable; always return to IDLE.
//  - ready = (state==IDLE & ~request) | (state==DONE). Latency per request = 2*WAIT_STATES+2
//    cycles from IDLE sample to the DONE cycle inclusive.
//  - Read and write both asserted: the store is performed; read_data is unchanged.
//  - read_data is updated only by reads; it holds its value otherwise.
//  - Back-to-back requests: DONE -> IDLE, then a new request starts the next cycle
//    (one idle bubble).
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: address[1:0]!=0 skips the SRAM access. Path is IDLE->DONE,
//    read_data=0, and extra output misaligned=1 during DONE.
//  Undefined: the misaligned port is absent; address[1:0] is ignored (forced word access).
// STRUCTURE
//  Shared ISA.v: `LEN_REGISTER and the new `LEN_SRAM_ADDR(18), `LEN_SRAM_DATA(16),
//  and state encodings `SRAM_IDLE/`SRAM_LO/`SRAM_HI/`SRAM_DONE (2 bits).
//  No sub-module; read_data halves use the existing Register module with ld gated per phase.
// TESTING (WAIT_STATES=5)
//  1. Store 0xDEADBEEF to addr 1024 -> SRAM[0]=0xBEEF, SRAM[1]=0xDEAD; freeze=1 for 11 cycles;
//     ready in cycle 12.
//  2. Load addr 1028 with SRAM[2]=0x5678, SRAM[3]=0x1234 -> read_data=0x12345678 in DONE;
//     SRAM_WE_N stays 1 throughout.
//  3. Two consecutive loads -> one idle bubble between them; the second result is correct;
//     read_data holds the first result until overwritten.
//  4. Assert rst in the HI phase of a store -> next cycle IDLE, SRAM_WE_N=1, SRAM_DQ=Z,
//     read_data=0.
//  5. Read and write asserted together with write_data=0xA5A5 -> store performed,
//     read_data unchanged.
//  6. MEM_ALIGN_CHECK_EN defined, load addr 1025 -> DONE in 2 cycles, misaligned=1,
//     no SRAM strobe.

Source files
------------

// File: rtl/sram_controller_pkg.sv
// ============================================================================
// Module      : sram_controller_pkg
// Description : Shared widths, FSM state encodings and the half-word address
//               helper for the MEM-stage SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_controller_pkg;

  localparam int LEN_REGISTER  = 32;
  localparam int LEN_SRAM_ADDR = 18;
  localparam int LEN_SRAM_DATA = 16;
  localparam int WORD_W        = LEN_SRAM_ADDR - 1;

  // Two-bit state encodings kept as plain constants for legacy compatibility
  localparam logic [1:0] SRAM_IDLE = 2'd0;
  localparam logic [1:0] SRAM_LO   = 2'd1;
  localparam logic [1:0] SRAM_HI   = 2'd2;
  localparam logic [1:0] SRAM_DONE = 2'd3;

  typedef logic [LEN_REGISTER-1:0]  word_t;
  typedef logic [LEN_SRAM_ADDR-1:0] sram_addr_t;
  typedef logic [LEN_SRAM_DATA-1:0] sram_data_t;

  // Byte address -> SRAM half-word address; upper word bits wrap silently
  function automatic sram_addr_t half_addr(input word_t address, input word_t base,
                                           input logic half);
    return {WORD_W'((address - base) >> 2), half};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_controller_if.sv
// ============================================================================
// Module      : sram_controller_if
// Description : Pipeline-side request/response bundle of the SRAM controller.
//               The misaligned flag exists only when MEM_ALIGN_CHECK_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_controller_if;
  import sram_controller_pkg::*;

  logic  mem_read_en;
  logic  mem_write_en;
  word_t address;
  word_t write_data;
  word_t read_data;
  logic  ready;
  logic  freeze;
`ifdef MEM_ALIGN_CHECK_EN
  logic  misaligned;

  modport master (output mem_read_en, mem_write_en, address, write_data,
                  input  read_data, ready, freeze, misaligned);
  modport slave  (input  mem_read_en, mem_write_en, address, write_data,
                  output read_data, ready, freeze, misaligned);
`else
  modport master (output mem_read_en, mem_write_en, address, write_data,
                  input  read_data, ready, freeze);
  modport slave  (input  mem_read_en, mem_write_en, address, write_data,
                  output read_data, ready, freeze);
`endif

endinterface

`default_nettype wire

// File: rtl/sram_controller.sv
// ============================================================================
// Module      : sram_controller
// Description : MEM-stage data-memory engine. Each 32-bit load/store becomes
//               two half-word accesses (low then high) to a 16-bit async
//               SRAM, each held for WAIT_STATES cycles. freeze stalls the
//               pipeline until the DONE cycle. Optional MEM_ALIGN_CHECK_EN
//               skips the SRAM for misaligned addresses and flags them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_STATES = 5
) (
  input  wire                     clk,
  input  wire                     rst,
  sram_controller_if.slave        mem,
  output logic [LEN_SRAM_ADDR-1:0] SRAM_ADDR,
  inout  wire  [LEN_SRAM_DATA-1:0] SRAM_DQ,
  output logic                    SRAM_WE_N,
  output logic                    SRAM_UB_N,
  output logic                    SRAM_LB_N,
  output logic                    SRAM_CE_N,
  output logic                    SRAM_OE_N
);

  localparam int         CNT_W    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES - 1);
  localparam word_t      BASE     = word_t'(ADDR_BASE);

  logic [1:0]       state;
  logic [CNT_W-1:0] count;
  logic             op_write;
  sram_data_t       rdata_lo;
  sram_data_t       rdata_hi;

  logic       request;
  logic       phase_end;
  logic       in_access;
  logic       drive_dq;
  logic       misaligned_req;
  sram_data_t dq_out;

  assign request   = mem.mem_read_en | mem.mem_write_en;
  assign phase_end = (count == CNT_LAST);
  assign in_access = (state == SRAM_LO) || (state == SRAM_HI);

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_req = |mem.address[1:0];
`else
  assign misaligned_req = 1'b0;
`endif

  // Sequencer: IDLE -> LO -> HI -> DONE -> IDLE, WAIT_STATES cycles per half
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SRAM_IDLE;
      count    <= '0;
      op_write <= 1'b0;
    end else begin
      case (state)
        SRAM_IDLE: begin
          count <= '0;
          if (request) begin
            // A store wins when both enables are set
            op_write <= mem.mem_write_en;
            state    <= misaligned_req ? SRAM_DONE : SRAM_LO;
          end
        end
        SRAM_LO: begin
          if (phase_end) begin
            count <= '0;
            state <= SRAM_HI;
          end else begin
            count <= count + 1'b1;
          end
        end
        SRAM_HI: begin
          if (phase_end) begin
            count <= '0;
            state <= SRAM_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          count <= '0;
          state <= SRAM_IDLE;
        end
      endcase
    end
  end

  // Load halves captured on the last wait cycle of their phase, loads only
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_lo <= '0;
      rdata_hi <= '0;
    end else if (state == SRAM_IDLE && request && misaligned_req) begin
      rdata_lo <= '0;
      rdata_hi <= '0;
    end else begin
      if (state == SRAM_LO && phase_end && !op_write) rdata_lo <= SRAM_DQ;
      if (state == SRAM_HI && phase_end && !op_write) rdata_hi <= SRAM_DQ;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic mis_flag;

  // Remember whether the current request took the misaligned shortcut
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_flag <= 1'b0;
    end else if (state == SRAM_IDLE && request) begin
      mis_flag <= misaligned_req;
    end
  end

  assign mem.misaligned = (state == SRAM_DONE) && mis_flag;
`endif

  // SRAM pin drive: address per half, data and strobe only for stores;
  // the strobe releases on the last cycle so data is held past WE_N rising
  assign drive_dq  = in_access && op_write;
  assign dq_out    = (state == SRAM_HI) ? mem.write_data[31:16] : mem.write_data[15:0];
  assign SRAM_DQ   = drive_dq ? dq_out : {LEN_SRAM_DATA{1'bz}};
  assign SRAM_WE_N = ~(drive_dq && !phase_end);
  assign SRAM_ADDR = (state == SRAM_LO) ? half_addr(mem.address, BASE, 1'b0) :
                     (state == SRAM_HI) ? half_addr(mem.address, BASE, 1'b1) :
                     '0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

  // Pipeline handshake
  assign mem.read_data = {rdata_hi, rdata_lo};
  assign mem.ready     = ((state == SRAM_IDLE) && !request) || (state == SRAM_DONE);
  assign mem.freeze    = request && !mem.ready;

endmodule

`default_nettype wire
